// File: rtl/lc3_memaccess.sv
// lc3_memaccess: memory-access stage of the LC3 pipeline.
// Runs the data-memory handshake for LD/LDR/ST/STR (one access) and
// LDI/STI (pointer read followed by the data access), with a per-access
// timeout.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle request, sampled only in IDLE
//   mem_op          00 read, 01 write, 10 indirect read, 11 indirect write
//   M_Addr, M_Data  effective address and store data from execute
//   Data_dout       data-memory read data
//   complete_data   data-memory completion for the current access
//   Data_addr       memory address
//   Data_din        memory write data
//   Data_rd         1 = read, 0 = write
//   Data_en         access request valid
//   memout          load result to writeback
//   busy            operation in progress
//   done, err       one-cycle completion / timeout pulses
module lc3_memaccess #(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned AW      = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [1:0]    mem_op,
   input  logic [AW-1:0] M_Addr,
   input  logic [AW-1:0] M_Data,
   input  logic [AW-1:0] Data_dout,
   input  logic          complete_data,
   output logic [AW-1:0] Data_addr,
   output logic [AW-1:0] Data_din,
   output logic          Data_rd,
   output logic          Data_en,
   output logic [AW-1:0] memout,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TLIM = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, IND, RD, WR} state_t;

   state_t        state_q;
   logic [AW-1:0] addr_q;
   logic [AW-1:0] data_q;
   logic [1:0]    op_q;
   logic [CW-1:0] cnt_q;
   logic          rd_q;
   logic          en_q;
   logic [AW-1:0] mem_q;
   logic          busy_q;
   logic          done_q;
   logic          err_q;
   logic          expire_d;

   // Current access has waited its full budget without completion.
   always_comb begin
      expire_d = 1'b0;
      if (TIMEOUT != 0)
         expire_d = (cnt_q == TLIM);
   end

   // All handshake outputs are registers, so they never glitch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
         rd_q    <= 1'b1;
         en_q    <= 1'b0;
         mem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  addr_q <= M_Addr;
                  data_q <= M_Data;
                  op_q   <= mem_op;
                  cnt_q  <= '0;
                  en_q   <= 1'b1;
                  busy_q <= 1'b1;
                  rd_q   <= (mem_op != 2'b01);
                  if (mem_op[1])
                     state_q <= IND;
                  else if (mem_op[0])
                     state_q <= WR;
                  else
                     state_q <= RD;
               end
            end
            default: begin
               // IND, RD and WR share completion and timeout handling.
               if (complete_data) begin
                  cnt_q <= '0;
                  if (state_q == IND) begin
                     // Pointer fetched: it becomes the data-access address.
                     addr_q <= Data_dout;
                     if (op_q == 2'b11) begin
                        state_q <= WR;
                        rd_q    <= 1'b0;
                     end else begin
                        state_q <= RD;
                        rd_q    <= 1'b1;
                     end
                  end else begin
                     if (state_q == RD)
                        mem_q <= Data_dout;
                     state_q <= IDLE;
                     en_q    <= 1'b0;
                     rd_q    <= 1'b1;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end else if (expire_d) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
                  en_q    <= 1'b0;
                  rd_q    <= 1'b1;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
         endcase
      end
   end

   assign Data_addr = addr_q;
   assign Data_din  = data_q;
   assign Data_rd   = rd_q;
   assign Data_en   = en_q;
   assign memout    = mem_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule
